dmem_responder: RTL and testbench

- Data-memory responder: the target end of the MEM-stage load/store interface.
- Accepts one request at a time from the pipelined core's MEM stage via a valid/ready handshake. Performs a 64-bit doubleword read or write on an internal array. Returns a response after a fixed, configurable latency.
- Replaces the zero-latency combinational data memory, so the pipeline can be verified against a real stalling memory.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address decode for the MEM-stage data memory responder.
package dmem_pkg;

  localparam int DMEM_XLEN       = 64;
  localparam int DMEM_DEPTH_LOG2 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [DMEM_XLEN-1:0] index;
    logic                 misaligned;
    logic                 out_of_range;
  } dmem_dec_t;

  // Index is already masked to depth_log2 bits; anything above the array is out of range.
  function automatic dmem_dec_t dmem_decode(input logic [DMEM_XLEN-1:0] addr,
                                            input int unsigned depth_log2);
    dmem_dec_t d;
    d.index        = (addr >> 3) & ((64'd1 << depth_log2) - 64'd1);
    d.misaligned   = |addr[2:0];
    d.out_of_range = |(addr >> (depth_log2 + 3));
    return d;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage and the data memory.
interface dmem_responder_if #(parameter int XLEN = dmem_pkg::DMEM_XLEN);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic [4:0]      rsp_rd;
  logic            rsp_write;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_write, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_write, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read of the same address.
module dmem_array #(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic [XLEN-1:0]       rdata_o
);

  logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed LATENCY (1..15) from accept to response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN       = DMEM_XLEN,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
  parameter int LATENCY    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int CNT_W = 4;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [4:0]       rd_q, rd_d;
  logic             write_q, write_d;
  logic             err_q, err_d;

  dmem_dec_t             dec;
  logic                  req_err;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [XLEN-1:0]       arr_rdata;

  assign dec     = dmem_decode(DMEM_XLEN'(bus.req_addr), DEPTH_LOG2);
  assign req_err = dec.misaligned | dec.out_of_range;
  assign arr_idx = DEPTH_LOG2'(dec.index);

  dmem_array #(
    .XLEN       (XLEN),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (arr_idx),
    .wdata_i (bus.req_wdata),
    .rdata_o (arr_rdata)
  );

  // Load data is taken from the pre-edge array contents, so a store never forwards to itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    write_d = write_q;
    err_d   = err_q;
    arr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          arr_we  = bus.req_write & ~req_err;
          rdata_d = (bus.req_write | req_err) ? '0 : arr_rdata;
          rd_d    = bus.req_rd;
          write_d = bus.req_write;
          err_d   = req_err;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_write = write_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 responder driven from a vector table, LATENCY=1 responder streamed.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if if2 ();
  dmem_responder_if if1 ();

  dmem_responder #(.LATENCY(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
  dmem_responder #(.LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  logic [63:0] s_addr[4];
  logic [63:0] s_wdata[4];
  logic        s_wr[4];
  logic [63:0] s_exp[4];
  int          acc_cyc[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called #1 after an edge with rsp_ready=1; returns #1 after the response has been consumed.
  task automatic txn2(input vec_t v, input string tag);
    int n;
    if2.req_write = v.wr;
    if2.req_addr  = v.addr;
    if2.req_wdata = v.wdata;
    if2.req_rd    = v.rd;
    if2.req_valid = 1'b1;
    n = 0;
    while (!if2.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!if2.req_ready) chk({tag, " accept timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    n = 0;
    while (!if2.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " extra edges to rsp"}, 64'(n), 64'd1);
    chk({tag, " rdata"}, if2.rsp_rdata, v.exp_rdata);
    chk({tag, " rd"}, 64'(if2.rsp_rd), 64'(v.rd));
    chk({tag, " write"}, 64'(if2.rsp_write), 64'(v.wr));
    chk({tag, " err"}, 64'(if2.rsp_err), 64'(v.exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, ai, ri, cyc;
    logic acc;

    vecs[0]  = '{1'b1, 64'h10,  64'hDEADBEEF, 5'd5,  64'h0,        1'b0};
    vecs[1]  = '{1'b0, 64'h10,  64'h0,        5'd7,  64'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 64'h13,  64'h1111,     5'd1,  64'h0,        1'b1};
    vecs[3]  = '{1'b0, 64'h10,  64'h0,        5'd2,  64'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 64'h800, 64'h0,        5'd3,  64'h0,        1'b1};
    vecs[5]  = '{1'b1, 64'h0,   64'h1234,     5'd12, 64'h0,        1'b0};
    vecs[6]  = '{1'b1, 64'h7F8, 64'hA5,       5'd4,  64'h0,        1'b0};
    vecs[7]  = '{1'b0, 64'h7F8, 64'h0,        5'd6,  64'hA5,       1'b0};
    vecs[8]  = '{1'b0, 64'h0,   64'h0,        5'd8,  64'h1234,     1'b0};
    vecs[9]  = '{1'b0, 64'h8000_0000_0000_0000, 64'h0, 5'd13, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 64'h4,   64'h0,        5'd14, 64'h0,        1'b1};
    vecs[11] = '{1'b1, 64'h17,  64'hFFFF,     5'd15, 64'h0,        1'b1};

    s_addr  = '{64'h0, 64'h8, 64'h0, 64'h8};
    s_wdata = '{64'h11, 64'h22, 64'h0, 64'h0};
    s_wr    = '{1'b1, 1'b1, 1'b0, 1'b0};
    s_exp   = '{64'h0, 64'h0, 64'h11, 64'h22};

    if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = '0;
    if2.req_wdata = '0;   if2.req_rd = '0;      if2.rsp_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0;
    if1.req_wdata = '0;   if1.req_rd = '0;      if1.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(if2.req_ready), 64'd1);
    chk("reset rsp_valid", 64'(if2.rsp_valid), 64'd0);
    chk("reset rsp_rdata", if2.rsp_rdata, 64'd0);
    chk("reset rsp_rd", 64'(if2.rsp_rd), 64'd0);
    chk("reset rsp_write", 64'(if2.rsp_write), 64'd0);
    chk("reset rsp_err", 64'(if2.rsp_err), 64'd0);
    chk("reset l1 req_ready", 64'(if1.req_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) txn2(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held while a new request waits.
    if2.rsp_ready = 1'b0;
    if2.req_write = 1'b0; if2.req_addr = 64'h10; if2.req_rd = 5'd10; if2.req_valid = 1'b1;
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    n = 0;
    while (!if2.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp rsp arrives", 64'(if2.rsp_valid), 64'd1);
    if2.req_addr = 64'h7F8; if2.req_rd = 5'd9; if2.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp req_ready low", 64'(if2.req_ready), 64'd0);
      chk("bp rsp_valid held", 64'(if2.rsp_valid), 64'd1);
      chk("bp rdata stable", if2.rsp_rdata, 64'hDEADBEEF);
      chk("bp rd stable", 64'(if2.rsp_rd), 64'd10);
      @(posedge clk); #1;
    end
    if2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp idle rsp_valid", 64'(if2.rsp_valid), 64'd0);
    chk("bp idle req_ready", 64'(if2.req_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp pending accepted", 64'(if2.req_ready), 64'd0);
    if2.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp2 rsp_valid", 64'(if2.rsp_valid), 64'd1);
    chk("bp2 rdata", if2.rsp_rdata, 64'hA5);
    chk("bp2 rd", 64'(if2.rsp_rd), 64'd9);
    @(posedge clk); #1;

    // Reset while BUSY: the committed store survives, its response is dropped.
    if2.req_write = 1'b1; if2.req_addr = 64'h18; if2.req_wdata = 64'h55;
    if2.req_rd = 5'd11; if2.req_valid = 1'b1;
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    chk("rst busy req_ready", 64'(if2.req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst after req_ready", 64'(if2.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst no rsp_valid", 64'(if2.rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    txn2('{1'b0, 64'h18, 64'h0, 5'd16, 64'h55, 1'b0}, "rst load");

    // LATENCY=1 stream with req_valid held: accepts every other edge.
    ai = 0; ri = 0; cyc = 0;
    if1.req_write = s_wr[0]; if1.req_addr = s_addr[0]; if1.req_wdata = s_wdata[0];
    if1.req_rd = 5'd20; if1.req_valid = 1'b1;
    for (int c = 0; c < 30 && ri < 4; c++) begin
      acc = if1.req_valid & if1.req_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[ai] = cyc;
        if (ai > 0) chk("l1 accept spacing", 64'(cyc - acc_cyc[ai-1]), 64'd2);
        ai++;
        if (ai < 4) begin
          if1.req_write = s_wr[ai]; if1.req_addr = s_addr[ai];
          if1.req_wdata = s_wdata[ai]; if1.req_rd = 5'(20 + ai);
        end else begin
          if1.req_valid = 1'b0;
        end
      end
      if (if1.rsp_valid && ri < ai) begin
        chk("l1 rsp one cycle after accept", 64'(cyc), 64'(acc_cyc[ri]));
        chk("l1 rdata", if1.rsp_rdata, s_exp[ri]);
        chk("l1 rd", 64'(if1.rsp_rd), 64'(20 + ri));
        ri++;
      end
    end
    chk("l1 responses seen", 64'(ri), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
